// File: rtl/fluid_seq_pkg.sv
// Shared types and helpers for the fluidic valve/mixer sequencer.
// Stage lengths are packed per channel; ch_len() pulls out one channel's field.
package fluid_seq_pkg;

    typedef enum logic [2:0] {IDLE, DOSE, DWELL, MIX, FLUSH, FIN} state_e;

    localparam int unsigned DEF_CNT_W = 16;
    localparam int unsigned MAX_CH    = 8;
    localparam int unsigned MAX_W     = 32;

    // vec is the zero-extended packed length bus; w is the per-channel field width
    function automatic logic [MAX_W-1:0] ch_len(input logic [MAX_CH*MAX_W-1:0] vec,
                                                input int unsigned k,
                                                input int unsigned w);
        logic [MAX_CH*MAX_W-1:0] sh;
        logic [MAX_W-1:0]        mask;
        sh   = vec >> (k * w);
        mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
        return sh[MAX_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/fluid_seq_ctrl_stage_timer.sv
// Shared down-counter for the active stage: loads L-1 on entry, expires at 0.
// Zero-length stages never reach the timer; the sequencer skips them itself.
module stage_timer #(
    parameter int unsigned CNT_W = fluid_seq_pkg::DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] len,
    input  logic             active,
    output logic             expire
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= (len == '0) ? '0 : len - CNT_W'(1);
        end else if (active && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign expire = active && (cnt == '0);

endmodule

// File: rtl/fluid_seq_ctrl.sv
// Programmable dose/dwell/mix/flush sequencer driving the chip's pneumatic valves.
// Stages run in a fixed linear order; zero-length stages are skipped in the same decision.
module fluid_seq_ctrl
    import fluid_seq_pkg::*;
#(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned CNT_W  = DEF_CNT_W,
    parameter int unsigned IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [NUM_CH*CNT_W-1:0] dose_len,
    input  logic [NUM_CH*CNT_W-1:0] dwell_len,
    input  logic [CNT_W-1:0]        mix_len,
    input  logic [CNT_W-1:0]        flush_len,
    output logic [NUM_CH-1:0]       valve_o,
    output logic                    mix_en,
    output logic                    flush_o,
    output logic                    busy,
    output logic [IDX_W-1:0]        ch_idx,
    output logic                    done,
    output logic                    err
);

    // Positions: DOSE(k)=2k, DWELL(k)=2k+1, MIX=2N, FLUSH=2N+1
    localparam int unsigned NPOS = 2 * NUM_CH + 2;

    state_e                  state, state_n;
    logic [IDX_W-1:0]        ch, ch_n;
    logic                    aborted, aborted_n;
    logic [NUM_CH*CNT_W-1:0] dose_q, dwell_q;
    logic [CNT_W-1:0]        mix_q, flush_q;
    logic                    latch, load, expire, active;
    logic [CNT_W-1:0]        load_len;
    logic [CNT_W-1:0]        plen [NPOS];

    // In IDLE the first stage is chosen from the live inputs, which are latched on the same edge
    always_comb begin
        logic [MAX_CH*MAX_W-1:0] dose_ext, dwell_ext;
        logic [MAX_W-1:0]        tmp;
        dose_ext  = '0;
        dwell_ext = '0;
        if (state == IDLE) begin
            dose_ext[NUM_CH*CNT_W-1:0]  = dose_len;
            dwell_ext[NUM_CH*CNT_W-1:0] = dwell_len;
            plen[2*NUM_CH]              = mix_len;
            plen[2*NUM_CH+1]            = flush_len;
        end else begin
            dose_ext[NUM_CH*CNT_W-1:0]  = dose_q;
            dwell_ext[NUM_CH*CNT_W-1:0] = dwell_q;
            plen[2*NUM_CH]              = mix_q;
            plen[2*NUM_CH+1]            = flush_q;
        end
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            tmp          = ch_len(dose_ext, k, CNT_W);
            plen[2*k]    = tmp[CNT_W-1:0];
            tmp          = ch_len(dwell_ext, k, CNT_W);
            plen[2*k+1]  = tmp[CNT_W-1:0];
        end
    end

    always_comb begin
        logic             seek_en, found;
        int unsigned      seek_from, fpos;
        logic [CNT_W-1:0] flen;
        state_n   = state;
        ch_n      = ch;
        aborted_n = aborted;
        latch     = 1'b0;
        load      = 1'b0;
        load_len  = '0;
        seek_en   = 1'b0;
        seek_from = 0;
        found     = 1'b0;
        fpos      = 0;
        flen      = '0;

        case (state)
            DOSE:    seek_from = 2 * int'(ch) + 1;
            DWELL:   seek_from = 2 * int'(ch) + 2;
            MIX:     seek_from = 2 * NUM_CH + 1;
            default: seek_from = 0;
        endcase

        for (int unsigned p = 0; p < NPOS; p++) begin
            if (!found && p >= seek_from && plen[p] != '0) begin
                found = 1'b1;
                fpos  = p;
                flen  = plen[p];
            end
        end

        case (state)
            IDLE: begin
                aborted_n = 1'b0;
                if (start && !abort) begin
                    latch   = 1'b1;
                    seek_en = 1'b1;
                end
            end
            DOSE, DWELL, MIX: begin
                if (abort) begin
                    aborted_n = 1'b1;
                    ch_n      = '0;
                    if (flush_q != '0) begin
                        state_n  = FLUSH;
                        load     = 1'b1;
                        load_len = flush_q;
                    end else begin
                        state_n = FIN;
                    end
                end else if (expire) begin
                    seek_en = 1'b1;
                end
            end
            FLUSH: if (expire) state_n = FIN;
            FIN: begin
                state_n   = IDLE;
                aborted_n = 1'b0;
            end
            default: state_n = IDLE;
        endcase

        if (seek_en) begin
            ch_n = '0;
            if (!found) begin
                state_n = FIN;
            end else begin
                load     = 1'b1;
                load_len = flen;
                if (fpos < 2 * NUM_CH) begin
                    state_n = fpos[0] ? DWELL : DOSE;
                    ch_n    = IDX_W'(fpos >> 1);
                end else if (fpos == 2 * NUM_CH) begin
                    state_n = MIX;
                end else begin
                    state_n = FLUSH;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ch      <= '0;
            aborted <= 1'b0;
            dose_q  <= '0;
            dwell_q <= '0;
            mix_q   <= '0;
            flush_q <= '0;
        end else begin
            state   <= state_n;
            ch      <= ch_n;
            aborted <= aborted_n;
            if (latch) begin
                dose_q  <= dose_len;
                dwell_q <= dwell_len;
                mix_q   <= mix_len;
                flush_q <= flush_len;
            end
        end
    end

    assign active = (state == DOSE) || (state == DWELL) || (state == MIX) || (state == FLUSH);

    stage_timer #(.CNT_W(CNT_W)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .len    (load_len),
        .active (active),
        .expire (expire)
    );

    always_comb begin
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            valve_o[k] = (state == DOSE) && (ch == IDX_W'(k));
        end
    end

    assign mix_en  = (state == MIX);
    assign flush_o = (state == FLUSH);
    assign busy    = active;
    assign ch_idx  = ((state == DOSE) || (state == DWELL)) ? ch : '0;
    assign done    = (state == FIN);
    assign err     = (state == FIN) && aborted;

endmodule

// File: tb/tb_fluid_seq_ctrl.sv
// Randomised and directed checks of fluid_seq_ctrl against a per-cycle trace model
// built from the stage lengths (segment lists, abort truncation, flush purge).
module tb_fluid_seq_ctrl;

    localparam int unsigned NCH = 3;
    localparam int unsigned CW  = 16;
    localparam int unsigned IW  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [NCH*CW-1:0] dose_len = '0;
    logic [NCH*CW-1:0] dwell_len = '0;
    logic [CW-1:0]     mix_len = '0;
    logic [CW-1:0]     flush_len = '0;
    logic [NCH-1:0]    valve_o;
    logic              mix_en, flush_o, busy, done, err;
    logic [IW-1:0]     ch_idx;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fluid_seq_ctrl #(.NUM_CH(NCH), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .dose_len  (dose_len),
        .dwell_len (dwell_len),
        .mix_len   (mix_len),
        .flush_len (flush_len),
        .valve_o   (valve_o),
        .mix_en    (mix_en),
        .flush_o   (flush_o),
        .busy      (busy),
        .ch_idx    (ch_idx),
        .done      (done),
        .err       (err)
    );

    typedef struct packed {
        logic [NCH-1:0] valve;
        logic           mix;
        logic           flush;
        logic           busy;
        logic [IW-1:0]  ch;
        logic           done;
        logic           err;
    } obs_t;

    int unsigned d_len [NCH];
    int unsigned w_len [NCH];
    int unsigned m_len, f_len;
    obs_t        expq [$];
    bit          abortable [$];

    function automatic obs_t observe();
        obs_t o;
        o = {valve_o, mix_en, flush_o, busy, ch_idx, done, err};
        return o;
    endfunction

    function automatic obs_t mk(input int vch, input bit mx, input bit fl, input bit bz,
                                input int ch, input bit dn, input bit er);
        obs_t o;
        o = '0;
        if (vch >= 0) o.valve[vch] = 1'b1;
        o.mix = mx; o.flush = fl; o.busy = bz;
        o.ch = IW'(ch); o.done = dn; o.err = er;
        return o;
    endfunction

    // Expected output per cycle 1..N after the start edge, from the lengths alone
    task automatic build(input int unsigned abort_at);
        expq.delete();
        abortable.delete();
        for (int k = 0; k < NCH; k++) begin
            repeat (d_len[k]) begin expq.push_back(mk(k, 0, 0, 1, k, 0, 0)); abortable.push_back(1); end
            repeat (w_len[k]) begin expq.push_back(mk(-1, 0, 0, 1, k, 0, 0)); abortable.push_back(1); end
        end
        repeat (m_len) begin expq.push_back(mk(-1, 1, 0, 1, 0, 0, 0)); abortable.push_back(1); end
        repeat (f_len) begin expq.push_back(mk(-1, 0, 1, 1, 0, 0, 0)); abortable.push_back(0); end
        if (abort_at > 0 && abort_at <= expq.size() && abortable[abort_at-1]) begin
            while (expq.size() > abort_at) expq.pop_back();
            repeat (f_len) expq.push_back(mk(-1, 0, 1, 1, 0, 0, 0));
            expq.push_back(mk(-1, 0, 0, 0, 0, 1, 1));
        end else begin
            expq.push_back(mk(-1, 0, 0, 0, 0, 1, 0));
        end
    endtask

    task automatic drive_lengths();
        for (int k = 0; k < NCH; k++) begin
            dose_len[k*CW +: CW]  = CW'(d_len[k]);
            dwell_len[k*CW +: CW] = CW'(w_len[k]);
        end
        mix_len   = CW'(m_len);
        flush_len = CW'(f_len);
    endtask

    task automatic run(input int unsigned abort_at, input int unsigned start_at,
                       input bit tamper, input string name);
        obs_t got;
        int   dones;
        build(abort_at);
        dones = 0;
        @(negedge clk);
        drive_lengths();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        if (tamper) begin
            for (int k = 0; k < NCH; k++) begin
                dose_len[k*CW +: CW]  = CW'($urandom_range(0, 9));
                dwell_len[k*CW +: CW] = CW'($urandom_range(0, 9));
            end
            mix_len   = CW'($urandom_range(0, 9));
            flush_len = CW'($urandom_range(0, 9));
        end
        for (int unsigned c = 1; c <= expq.size(); c++) begin
            @(negedge clk);
            got = observe();
            if (got.done) dones++;
            vectors++;
            if (got !== expq[c-1]) begin
                miscompares++;
                $display("FAIL %s cycle %0d: got %b expected %b", name, c, got, expq[c-1]);
            end
            abort = (c == abort_at);
            start = (c == start_at);
        end
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        got = observe();
        vectors++;
        if (got !== obs_t'('0) || dones != 1) begin
            miscompares++;
            $display("FAIL %s_idle_after: got %b dones %0d expected 0 dones 1", name, got, dones);
        end
    endtask

    task automatic set_plan();
        d_len = '{2, 3, 4};
        w_len = '{5, 0, 1};
        m_len = 6;
        f_len = 2;
    endtask

    task automatic test_reset();
        obs_t got;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        got = observe();
        vectors++;
        if (got !== obs_t'('0)) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b expected 0", got);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_plan_sequence();
        set_plan();
        run(0, 0, 0, "plan");
        run(9, 0, 0, "plan_abort_dose1");
        run(0, 0, 0, "plan_after_abort");
        run(0, 5, 0, "start_while_busy");
        run(0, 0, 1, "latched_lengths");
        run(18, 0, 0, "abort_in_mix");
        run(22, 0, 0, "abort_in_flush_ignored");
    endtask

    task automatic test_all_zero();
        d_len = '{0, 0, 0};
        w_len = '{0, 0, 0};
        m_len = 0;
        f_len = 0;
        run(0, 0, 0, "all_zero");
        d_len = '{0, 2, 0};
        f_len = 0;
        run(1, 0, 0, "abort_zero_flush");
    endtask

    task automatic test_start_abort_idle();
        obs_t got;
        set_plan();
        @(negedge clk);
        drive_lengths();
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        abort = 1'b0;
        repeat (4) begin
            @(negedge clk);
            got = observe();
            vectors++;
            if (got !== obs_t'('0)) begin
                miscompares++;
                $display("FAIL start_abort_idle: got %b expected 0", got);
            end
        end
    endtask

    task automatic test_reset_mid_mix();
        obs_t got;
        set_plan();
        build(0);
        @(negedge clk);
        drive_lengths();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (17) @(negedge clk);
        vectors++;
        if (mix_en !== 1'b1) begin
            miscompares++;
            $display("FAIL mix_before_reset: got %b expected 1", mix_en);
        end
        #1 rst_n = 1'b0;
        #1 got = observe();
        vectors++;
        if (got !== obs_t'('0)) begin
            miscompares++;
            $display("FAIL async_reset_mix: got %b expected 0", got);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        got = observe();
        vectors++;
        if (got !== obs_t'('0)) begin
            miscompares++;
            $display("FAIL idle_after_reset: got %b expected 0", got);
        end
        run(0, 0, 0, "run_after_reset");
    endtask

    task automatic test_random();
        int unsigned total, ab;
        for (int r = 0; r < 25; r++) begin
            total = 0;
            for (int k = 0; k < NCH; k++) begin
                d_len[k] = $urandom_range(0, 4);
                w_len[k] = $urandom_range(0, 4);
                total += d_len[k] + w_len[k];
            end
            m_len = $urandom_range(0, 4);
            f_len = $urandom_range(0, 3);
            total += m_len + f_len;
            ab = ($urandom_range(0, 2) == 0 && total > 0) ? $urandom_range(1, total) : 0;
            run(ab, $urandom_range(0, 3), $urandom_range(0, 1), "random");
        end
    endtask

    task automatic test_long_dose();
        int unsigned on_cycles, cyc;
        bit          seen_done, stray;
        d_len = '{65535, 0, 0};
        w_len = '{0, 0, 0};
        m_len = 0;
        f_len = 0;
        on_cycles = 0;
        cyc = 0;
        seen_done = 0;
        stray = 0;
        @(negedge clk);
        drive_lengths();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        while (!seen_done && cyc < 70000) begin
            @(negedge clk);
            cyc++;
            if (valve_o == 3'b001) on_cycles++;
            else if (valve_o != '0 || mix_en || flush_o) stray = 1;
            if (done) seen_done = 1;
        end
        vectors++;
        if (!seen_done || cyc != 65536 || on_cycles != 65535 || stray || err !== 1'b0) begin
            miscompares++;
            $display("FAIL long_dose: done_cycle %0d valve_cycles %0d stray %0d err %b expected 65536 65535 0 0",
                     cyc, on_cycles, stray, err);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_plan_sequence();
        test_all_zero();
        test_start_abort_idle();
        test_reset_mid_mix();
        test_random();
        test_long_dose();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
